// File: rtl/data_path.sv
// Bus-oriented CPU datapath: register file, special registers, 64-bit Z and ALU on a 32-bit bus.
// Define DATA_PATH_DIV_EN to build the signed divider for opcode 13; otherwise opcode 13 yields 0.
module data_path (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] enable,
    input  logic [31:0] busSelect,
    input  logic [31:0] inPort,
    input  logic [31:0] MDataIn,
    input  logic        MD_Read,
    input  logic [3:0]  Control_Signals,
    output logic [31:0] busMuxOut
);

    localparam int unsigned EnHi      = 16;
    localparam int unsigned EnLo      = 17;
    localparam int unsigned EnPc      = 20;
    localparam int unsigned EnMdr     = 21;
    localparam int unsigned EnOutPort = 22;
    localparam int unsigned EnIr      = 23;
    localparam int unsigned EnZ       = 24;
    localparam int unsigned EnMar     = 25;
    localparam int unsigned EnInPort  = 26;
    localparam int unsigned EnY       = 27;
    localparam int unsigned EnIncPc   = 28;

    logic [31:0] r_q [16];
    logic [31:0] hi_q, lo_q, pc_q, mdr_q, ir_q, mar_q, y_q, inport_q, outport_q;
    logic [63:0] z_q;

    logic [31:0] bus_src [23];
    logic [63:0] alu_res;
    logic [63:0] z_d;

    logic        unused_bits;
    assign unused_bits = ^{enable[31:29], enable[19:18], busSelect[31:23]};

    // Bus sources in select-bit order
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            bus_src[i] = r_q[i];
        end
        bus_src[16] = hi_q;
        bus_src[17] = lo_q;
        bus_src[18] = z_q[63:32];
        bus_src[19] = z_q[31:0];
        bus_src[20] = pc_q;
        bus_src[21] = mdr_q;
        bus_src[22] = inport_q;
    end

    // Scan from the top so the lowest set select wins
    always_comb begin
        busMuxOut = '0;
        for (int i = 22; i >= 0; i--) begin
            if (busSelect[i]) begin
                busMuxOut = bus_src[i];
            end
        end
    end

    logic [31:0] a, b;
    logic [4:0]  sh;
    logic [63:0] aa, ror_w, rol_w;
    logic [31:0] sra_w;
    logic signed [63:0] mul_w;

    assign a     = y_q;
    assign b     = busMuxOut;
    assign sh    = b[4:0];
    assign aa    = {a, a};
    assign ror_w = aa >> sh;
    assign rol_w = aa << sh;
    assign sra_w = $signed(a) >>> sh;
    assign mul_w = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});

`ifdef DATA_PATH_DIV_EN
    logic signed [31:0] quo_w, rem_w;
    always_comb begin
        quo_w = '0;
        rem_w = '0;
        if (b != 32'h0) begin
            quo_w = $signed(a) / $signed(b);
            rem_w = $signed(a) % $signed(b);
        end
    end
`endif

    always_comb begin
        alu_res = '0;
        case (Control_Signals)
            4'd0:  alu_res = {32'h0, b};
            4'd1:  alu_res = {32'h0, a + b};
            4'd2:  alu_res = {32'h0, a - b};
            4'd3:  alu_res = {32'h0, a & b};
            4'd4:  alu_res = {32'h0, a | b};
            4'd5:  alu_res = {32'h0, a >> sh};
            4'd6:  alu_res = {32'h0, sra_w};
            4'd7:  alu_res = {32'h0, a << sh};
            4'd8:  alu_res = {32'h0, ror_w[31:0]};
            4'd9:  alu_res = {32'h0, rol_w[63:32]};
            4'd10: alu_res = {32'h0, 32'h0 - b};
            4'd11: alu_res = {32'h0, ~b};
            4'd12: alu_res = mul_w;
`ifdef DATA_PATH_DIV_EN
            4'd13: alu_res = {rem_w, quo_w};
`endif
            default: alu_res = '0;
        endcase
    end

    // PC increment path takes priority over the opcode
    assign z_d = enable[EnIncPc] ? {32'h0, b + 32'd1} : alu_res;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < 16; i++) begin
                r_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (enable[i]) begin
                    r_q[i] <= busMuxOut;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            hi_q      <= '0;
            lo_q      <= '0;
            pc_q      <= '0;
            mdr_q     <= '0;
            ir_q      <= '0;
            mar_q     <= '0;
            y_q       <= '0;
            inport_q  <= '0;
            outport_q <= '0;
            z_q       <= '0;
        end else begin
            if (enable[EnHi])      hi_q      <= busMuxOut;
            if (enable[EnLo])      lo_q      <= busMuxOut;
            if (enable[EnPc])      pc_q      <= busMuxOut;
            if (enable[EnMdr])     mdr_q     <= MD_Read ? MDataIn : busMuxOut;
            if (enable[EnIr])      ir_q      <= busMuxOut;
            if (enable[EnMar])     mar_q     <= busMuxOut;
            if (enable[EnY])       y_q       <= busMuxOut;
            if (enable[EnInPort])  inport_q  <= inPort;
            if (enable[EnOutPort]) outport_q <= busMuxOut;
            if (enable[EnZ])       z_q       <= z_d;
        end
    end

endmodule

// File: tb/tb_data_path.sv
// Self-checking bench for data_path; observes the bus plus a few internal registers.
// Honours DATA_PATH_DIV_EN the same way as the design.
module tb_data_path;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] enable, busSelect, inPort, MDataIn;
    logic        MD_Read;
    logic [3:0]  Control_Signals;
    logic [31:0] busMuxOut;

    data_path dut (
        .clk             (clk),
        .clr             (clr),
        .enable          (enable),
        .busSelect       (busSelect),
        .inPort          (inPort),
        .MDataIn         (MDataIn),
        .MD_Read         (MD_Read),
        .Control_Signals (Control_Signals),
        .busMuxOut       (busMuxOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] bit_of(input int i);
        logic [31:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic step(input logic [31:0] en, input logic [31:0] sel, input logic rd,
                        input logic [31:0] mdata, input logic [3:0] op);
        @(negedge clk);
        enable = en; busSelect = sel; MD_Read = rd; MDataIn = mdata; Control_Signals = op;
        @(posedge clk);
        #1;
        enable = '0; busSelect = '0; MD_Read = 1'b0;
    endtask

    task automatic set_reg(input int k, input logic [31:0] v);
        step(bit_of(21), '0, 1'b1, v, 4'd0);
        step(bit_of(k), bit_of(21), 1'b0, '0, 4'd0);
    endtask

    task automatic push_exp(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = {32'h0, v};
        sb.push_back(e);
    endtask

    task automatic read_sb(input logic [31:0] sel);
        exp_t e;
        busSelect = sel;
        enable = '0;
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 64'h1, 64'h0);
        end else begin
            e = sb.pop_front();
            check(e.tag, {32'h0, busMuxOut}, e.val);
        end
    endtask

    task automatic expect_bus(input string tag, input logic [31:0] sel, input logic [31:0] v);
        push_exp(tag, v);
        read_sb(sel);
    endtask

    // Reference ALU built from bit-serial operations
    function automatic logic [63:0] model_alu(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] r;
        logic [63:0] ea, eb;
        int sa, sbv;
        r = a;
        case (op)
            4'd0:  return {32'h0, b};
            4'd1:  begin r = a + b; return {32'h0, r}; end
            4'd2:  begin r = a - b; return {32'h0, r}; end
            4'd3:  return {32'h0, a & b};
            4'd4:  return {32'h0, a | b};
            4'd5:  begin repeat (int'(b[4:0])) r = {1'b0, r[31:1]}; return {32'h0, r}; end
            4'd6:  begin repeat (int'(b[4:0])) r = {r[31], r[31:1]}; return {32'h0, r}; end
            4'd7:  begin repeat (int'(b[4:0])) r = {r[30:0], 1'b0}; return {32'h0, r}; end
            4'd8:  begin repeat (int'(b[4:0])) r = {r[0], r[31:1]}; return {32'h0, r}; end
            4'd9:  begin repeat (int'(b[4:0])) r = {r[30:0], r[31]}; return {32'h0, r}; end
            4'd10: begin r = ~b + 32'd1; return {32'h0, r}; end
            4'd11: return {32'h0, ~b};
            4'd12: begin
                ea = {{32{a[31]}}, a};
                eb = {{32{b[31]}}, b};
                return ea * eb;
            end
`ifdef DATA_PATH_DIV_EN
            4'd13: begin
                if (b == 32'h0) return 64'h0;
                sa = a; sbv = b;
                return {32'(sa % sbv), 32'(sa / sbv)};
            end
`endif
            default: return 64'h0;
        endcase
    endfunction

    task automatic run_alu(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b);
        logic [63:0] exp;
        exp = model_alu(op, a, b);
        set_reg(1, a);
        step(bit_of(27), bit_of(1), 1'b0, '0, 4'd0);
        set_reg(2, b);
        push_exp({tag, "_zlo"}, exp[31:0]);
        push_exp({tag, "_zhi"}, exp[63:32]);
        step(bit_of(24), bit_of(2), 1'b0, '0, op);
        read_sb(bit_of(19));
        read_sb(bit_of(18));
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ra, rb;
        clr = 1'b0; enable = '0; busSelect = '0; inPort = '0; MDataIn = '0;
        MD_Read = 1'b0; Control_Signals = '0;
        #3;
        expect_bus("rst_r0", bit_of(0), 32'h0);
        expect_bus("rst_hi", bit_of(16), 32'h0);
        expect_bus("rst_zlo", bit_of(19), 32'h0);
        expect_bus("rst_pc", bit_of(20), 32'h0);
        expect_bus("rst_inport", bit_of(22), 32'h0);
        @(negedge clk);
        clr = 1'b1;

        // Bus priority and multi-enable
        set_reg(6, 32'h2);
        set_reg(7, 32'h5);
        expect_bus("mux_6_7", bit_of(6) | bit_of(7), 32'h2);
        expect_bus("mux_7_20", bit_of(7) | bit_of(20), 32'h5);
        expect_bus("mux_none", 32'h0, 32'h0);
        step(bit_of(8) | bit_of(9) | bit_of(16), bit_of(6), 1'b0, '0, 4'd0);
        expect_bus("multi_r8", bit_of(8), 32'h2);
        expect_bus("multi_r9", bit_of(9), 32'h2);
        expect_bus("multi_hi", bit_of(16), 32'h2);

        // MUL 2*2 through LO/HI
        set_reg(6, 32'h2);
        set_reg(7, 32'h2);
        step(bit_of(27), bit_of(6), 1'b0, '0, 4'd0);
        step(bit_of(24), bit_of(7), 1'b0, '0, 4'd12);
        step(bit_of(17), bit_of(19), 1'b0, '0, 4'd0);
        step(bit_of(16), bit_of(18), 1'b0, '0, 4'd0);
        expect_bus("mul_lo", bit_of(17), 32'h4);
        expect_bus("mul_hi", bit_of(16), 32'h0);

        run_alu("smul", 4'd12, 32'hFFFFFFFD, 32'h5);
        check("smul_const", model_alu(4'd12, 32'hFFFFFFFD, 32'h5), 64'hFFFFFFFF_FFFFFFF1);

        // DIV via LO/HI
        set_reg(1, 32'd7);
        step(bit_of(27), bit_of(1), 1'b0, '0, 4'd0);
        set_reg(2, 32'd2);
        step(bit_of(24), bit_of(2), 1'b0, '0, 4'd13);
        step(bit_of(17), bit_of(19), 1'b0, '0, 4'd0);
        step(bit_of(16), bit_of(18), 1'b0, '0, 4'd0);
`ifdef DATA_PATH_DIV_EN
        expect_bus("div_lo", bit_of(17), 32'd3);
        expect_bus("div_hi", bit_of(16), 32'd1);
`else
        expect_bus("div_lo", bit_of(17), 32'd0);
        expect_bus("div_hi", bit_of(16), 32'd0);
`endif
        run_alu("div0", 4'd13, 32'd7, 32'd0);

        // Every opcode with random operands, plus zero shift amounts
        for (int op = 0; op < 16; op++) begin
            for (int k = 0; k < 2; k++) begin
                ra = $urandom;
                rb = $urandom;
                if (k == 1 && op >= 5 && op <= 9) rb[4:0] = 5'd0;
                if (op == 13 && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'h1;
                run_alu($sformatf("alu_op%0d_%0d", op, k), 4'(op), ra, rb);
            end
        end

        // Instruction fetch using IncPC
        step(bit_of(20), bit_of(0), 1'b0, '0, 4'd0);
        step(bit_of(24) | bit_of(25) | bit_of(28), bit_of(20), 1'b0, '0, 4'd5);
        expect_bus("fetch_zlo", bit_of(19), 32'h1);
        step(bit_of(20) | bit_of(21), bit_of(19), 1'b1, 32'h7B380000, 4'd0);
        step(bit_of(23), bit_of(21), 1'b0, '0, 4'd0);
        expect_bus("fetch_pc", bit_of(20), 32'h1);
        check("fetch_mar", {32'h0, dut.mar_q}, 64'h0);
        check("fetch_ir", {32'h0, dut.ir_q}, 64'h7B380000);
        step(bit_of(28), bit_of(20), 1'b0, '0, 4'd0);
        expect_bus("incpc_no_zin", bit_of(19), 32'h1);

        // Same-register load and bus-out
        step(bit_of(21), '0, 1'b1, 32'h11, 4'd0);
        @(negedge clk);
        enable = bit_of(21); busSelect = bit_of(21); MD_Read = 1'b1; MDataIn = 32'h22;
        #1;
        check("same_reg_old", {32'h0, busMuxOut}, 64'h11);
        @(posedge clk);
        #1;
        check("same_reg_new", {32'h0, busMuxOut}, 64'h22);
        enable = '0; MD_Read = 1'b0;

        // Ports
        inPort = 32'hABCD1234;
        step(bit_of(26), '0, 1'b0, '0, 4'd0);
        expect_bus("inport", bit_of(22), 32'hABCD1234);
        step(bit_of(22), bit_of(22), 1'b0, '0, 4'd0);
        check("outport", {32'h0, dut.outport_q}, 64'hABCD1234);

        // Asynchronous reset between edges
        set_reg(6, 32'h2);
        step(bit_of(24), bit_of(6), 1'b0, '0, 4'd0);
        expect_bus("pre_rst_zlo", bit_of(19), 32'h2);
        clr = 1'b0;
        #1;
        check("rst_async_r6", {32'h0, dut.r_q[6]}, 64'h0);
        check("rst_async_z", dut.z_q, 64'h0);
        expect_bus("rst_bus_r6", bit_of(6), 32'h0);
        @(negedge clk);
        clr = 1'b1;
        expect_bus("rst_rel_r6", bit_of(6), 32'h0);
        inPort = 32'h9;
        step(bit_of(26), '0, 1'b0, '0, 4'd0);
        step(bit_of(6), bit_of(22), 1'b0, '0, 4'd0);
        expect_bus("post_rst_r6", bit_of(6), 32'h9);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
